// File: rtl/apb_requester_arbiter.sv
// APB requester-side bridge: round-robin arbitration of NUM_REQ local requesters
// onto one APB completer, with alignment check, PPROT generation and PREADY timeout.

package apb_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } state;

    // Upper half of the address map is the privileged, non-secure, instruction region.
    function automatic logic [2:0] getPprot(input logic [ADDR_WIDTH-1:0] addr);
        logic [2:0] prot_v;
        if (addr[ADDR_WIDTH-1]) begin
            prot_v = 3'b111;
        end else begin
            prot_v = 3'b000;
        end
        return prot_v;
    endfunction

    function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction
endpackage

module apb_requester_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
    output logic [NUM_REQ-1:0]               done,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_tmo,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [STRB_WIDTH-1:0]            PSTRB,
    output logic [2:0]                       PPROT,
    input  logic                             PREADY,
    input  logic                             PSLVERR,
    input  logic [DATA_WIDTH-1:0]            PRDATA
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state                    state_r;
    state                    state_nx_s;
    logic [PTR_W-1:0]        last_r;
    logic [PTR_W-1:0]        grant_s;
    logic                    found_s;
    logic                    start_s;
    logic                    complete_s;
    logic                    timeout_s;
    logic                    err_done_s;
    logic [NUM_REQ-1:0]      elig_s;
    logic [CNT_W-1:0]        cnt_r;

    logic [ADDR_WIDTH-1:0]   addr_a_s  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_a_s [NUM_REQ];
    logic [STRB_WIDTH-1:0]   strb_a_s  [NUM_REQ];

    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic [STRB_WIDTH-1:0]   pstrb_r;
    logic [2:0]              pprot_r;
    logic [NUM_REQ-1:0]      done_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_err_r;
    logic                    rsp_tmo_r;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a_s[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a_s[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign strb_a_s[i]  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
    end

    // A requester is being told it finished this cycle, so it must not be re-granted now.
    assign elig_s = req & ~done_r;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        idx_v   = last_r;
        found_s = 1'b0;
        grant_s = last_r;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = PTR_W'((int'(last_r) + k) % NUM_REQ);
            if (!found_s && elig_s[idx_v]) begin
                found_s = 1'b1;
                grant_s = idx_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Transfer sequencing: next state and the single-cycle events that drive the datapath.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        err_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    start_s    = 1'b1;
                    state_nx_s = validAlign(addr_a_s[grant_s]) ? SETUP : ERROR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETUP: begin
                state_nx_s = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    complete_s = 1'b1;
                    state_nx_s = IDLE;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    timeout_s  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = ACCESS;
                end
            end
            ERROR: begin
                err_done_s = 1'b1;
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant pointer, wait counter, APB bus registers and completion response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            last_r      <= PTR_W'(NUM_REQ - 1);
            cnt_r       <= {CNT_W{1'b0}};
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= {ADDR_WIDTH{1'b0}};
            pwdata_r    <= {DATA_WIDTH{1'b0}};
            pstrb_r     <= {STRB_WIDTH{1'b0}};
            pprot_r     <= 3'b000;
            done_r      <= {NUM_REQ{1'b0}};
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            rsp_tmo_r   <= 1'b0;
        end else begin
            psel_r    <= (state_nx_s == SETUP) || (state_nx_s == ACCESS);
            penable_r <= (state_nx_s == ACCESS);

            if (start_s) begin
                last_r   <= grant_s;
                paddr_r  <= addr_a_s[grant_s];
                pwrite_r <= req_write[grant_s];
                pwdata_r <= wdata_a_s[grant_s];
                pstrb_r  <= req_write[grant_s] ? strb_a_s[grant_s] : {STRB_WIDTH{1'b0}};
                pprot_r  <= getPprot(addr_a_s[grant_s]);
            end else begin
                last_r   <= last_r;
            end

            if (state_r == SETUP) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ACCESS) && !PREADY) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            done_r      <= {NUM_REQ{1'b0}};
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            rsp_tmo_r   <= 1'b0;
            if (complete_s) begin
                done_r      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << last_r;
                rsp_rdata_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : PRDATA;
                rsp_err_r   <= PSLVERR;
            end else if (timeout_s) begin
                done_r      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << last_r;
                rsp_err_r   <= 1'b1;
                rsp_tmo_r   <= 1'b1;
            end else if (err_done_s) begin
                done_r      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << last_r;
                rsp_err_r   <= 1'b1;
            end else begin
                done_r      <= {NUM_REQ{1'b0}};
            end
        end
    end

    assign PSEL      = psel_r;
    assign PENABLE   = penable_r;
    assign PWRITE    = pwrite_r;
    assign PADDR     = paddr_r;
    assign PWDATA    = pwdata_r;
    assign PSTRB     = pstrb_r;
    assign PPROT     = pprot_r;
    assign done      = done_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_tmo   = rsp_tmo_r;

endmodule
